fpga_count_ctrl: RTL and testbench
==================================

Name: fpga_count_ctrl

Overview:
Command-driven controller for the design's free-running ODW-bit counter.
- Sequences the counter: start/stop, load, clear, compare-match ticks (one-shot or periodic) and wrap detection.
- Returns counter snapshots through a valid/ready output stage.
- Sits between the control/debug fabric (command source) and consumers of `count`, `tick` and snapshot data, all in the `clk` domain.

Parameters:
- ODW, 32, counter/compare/snapshot data width in bits (bench also runs ODW=8).

Ports:
- clk  in  1  single design clock (post-BUFG)
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  opcode: 0 CLEAR, 1 LOAD_CMP, 2 LOAD_CNT, 3 START, 4 STOP, 5 SNAP, 6/7 reserved
- cmd_data  in  ODW  operand for LOAD_CMP / LOAD_CNT
- cfg_periodic  in  1  mode, sampled only on an accepted START from IDLE or DONE
- count  out  ODW  current counter value (registered)
- running  out  1  state==RUN
- done  out  1  state==DONE
- tick  out  1  one-cycle pulse, cycle after a compare match
- wrap  out  1  one-cycle pulse, cycle after count goes 2^ODW-1 -> 0
- snap_valid  out  1  snapshot available
- snap_ready  in  1  consumer accepts snapshot
- snap_data  out  ODW  captured count

Behaviour:
Interface:
- One clock, `clk`. Reset `rst` is synchronous, active-high.

Reset values:
- state=IDLE, count=0, cmp=all-ones, periodic=0.
- tick=0, wrap=0, snap_valid=0, snap_data=0, running=0, done=0.
- Reset asserted mid-run or with a snapshot pending discards everything; reset has priority over all commands.

States:
- IDLE: count holds.
- RUN: count increments each cycle.
- DONE: one-shot match reached, count holds.

Handshakes:
- cmd_ready = !snap_valid || snap_ready (combinational). Every command stalls while an unconsumed snapshot is held.
- Snapshot clears on snap_valid && snap_ready.

Commands (effect visible the cycle after acceptance):
- CLEAR: count<=0, state<=IDLE.
- LOAD_CMP: cmp<=cmd_data. State and count unaffected.
- LOAD_CNT: count<=cmd_data. State unchanged.
- START:
  - IDLE -> RUN, count continues from its current value.
  - DONE -> RUN with count<=0.
  - RUN: no effect, mode not resampled.
  - Samples periodic<=cfg_periodic when leaving IDLE or DONE.
- STOP: RUN/DONE -> IDLE, count holds.
- SNAP: snap_data<=count (pre-update value), snap_valid<=1. If accepted while snap_ready is high, the new data replaces the old and snap_valid stays 1.
- Reserved opcodes: accepted, no effect.

RUN counting (cycles with no overriding command):
- count==cmp: tick=1 next cycle.
  - periodic=1: count<=0, stay in RUN.
  - periodic=0: state<=DONE, count holds at cmp.
- else count==2^ODW-1: count<=0, wrap=1 next cycle.
- else count<=count+1.
- Match is checked before wrap, so cmp=all-ones produces tick only, no wrap.
- cmp=0: matches whenever count==0, so periodic mode ticks every cycle.

Simultaneous events:
- CLEAR, LOAD_CNT or STOP accepted in the same cycle as a match or wrap: the command wins, and tick/wrap are suppressed.
- LOAD_CMP, SNAP or START accepted during RUN: counting proceeds normally, and the match that cycle uses the old cmp.

Output registering:
- tick and wrap are registered, one cycle wide.
- running and done are registered state decodes.
- No combinational input-to-output paths except cmd_ready.

Decomposition:
- FPGA_skeleton_PKG gains:
  - `cnt_op_e` enum: 3-bit opcodes.
  - `cnt_state_e` enum: IDLE/RUN/DONE.
  - localparam CNT_ODW_DEFAULT=32.
- One sub-module: fpga_count_snap, a one-entry valid/ready output register holding snap_data and producing the ready term used in cmd_ready.

Test Plan (ODW=8):
- Reset, then idle 5 cycles -> count=0, snap_valid=0, cmd_ready=1, running=0.
- LOAD_CMP 4, START with cfg_periodic=0 -> running next cycle; count 0,1,2,3,4; tick one cycle after count=4; done=1; count holds at 4. START again -> count=0, running=1.
- LOAD_CMP 2, periodic START -> count sequence 0,1,2,0,1,2; tick every 3rd cycle, each lagging its count=2 cycle by one.
- LOAD_CNT 0xFE, cmp=0x10, START -> count 0xFE,0xFF,0x00; wrap pulses once; no tick until count=0x10.
- SNAP with snap_ready=0 while count=0x21 -> snap_data=0x21, snap_valid=1, cmd_ready=0; a STOP presented then stalls. Raise snap_ready -> snapshot consumed, STOP accepted in that same cycle, running=0 next cycle.
- In RUN with cmp=5, issue STOP in the cycle count==5 -> no tick, state=IDLE, count holds at 5. Assert rst mid-RUN -> all outputs return to reset values on the next clk edge.

Source files
------------

// File: rtl/fpga_count_ctrl_pkg.sv
// Shared types for the counter controller: command opcodes, FSM states, default width.
package fpga_count_ctrl_pkg;

   localparam int CNT_ODW_DEFAULT = 32;

   typedef enum logic [2:0] {
      OP_CLEAR    = 3'd0,
      OP_LOAD_CMP = 3'd1,
      OP_LOAD_CNT = 3'd2,
      OP_START    = 3'd3,
      OP_STOP     = 3'd4,
      OP_SNAP     = 3'd5,
      OP_RSVD6    = 3'd6,
      OP_RSVD7    = 3'd7
   } cnt_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cnt_state_e;

endpackage

// File: rtl/fpga_count_ctrl_if.sv
// Command and snapshot handshake bundle between the control fabric and fpga_count_ctrl.
interface fpga_count_ctrl_if
   import fpga_count_ctrl_pkg::*;
#(
   parameter int ODW = CNT_ODW_DEFAULT
) ();

   logic           cmd_valid;
   logic           cmd_ready;
   logic [2:0]     cmd_op;
   logic [ODW-1:0] cmd_data;
   logic           snap_valid;
   logic           snap_ready;
   logic [ODW-1:0] snap_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, snap_ready,
      input  cmd_ready, snap_valid, snap_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, snap_ready,
      output cmd_ready, snap_valid, snap_data
   );

endinterface

// File: rtl/fpga_count_snap.sv
// One-entry valid/ready snapshot register; free tells the command side a new
// snapshot (or any command) can be taken this cycle.
module fpga_count_snap
   import fpga_count_ctrl_pkg::*;
#(
   parameter int ODW = CNT_ODW_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [ODW-1:0] load_data,
   input  logic           snap_ready,
   output logic           snap_valid,
   output logic [ODW-1:0] snap_data,
   output logic           free
);

   assign free = !snap_valid || snap_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         snap_valid <= 1'b0;
         snap_data  <= '0;
      end else if (load) begin
         snap_valid <= 1'b1;
         snap_data  <= load_data;
      end else if (snap_valid && snap_ready) begin
         snap_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fpga_count_ctrl.sv
// Command-driven controller for a free-running counter with compare-match ticks,
// wrap detection and a valid/ready snapshot return path.
module fpga_count_ctrl
   import fpga_count_ctrl_pkg::*;
#(
   parameter int ODW = CNT_ODW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   fpga_count_ctrl_if.slave  bus,
   input  logic              cfg_periodic,
   output logic [ODW-1:0]    count,
   output logic              running,
   output logic              done,
   output logic              tick,
   output logic              wrap
);

   cnt_state_e     state, state_nxt;
   cnt_op_e        op;
   logic [ODW-1:0] cmp, cmp_nxt, count_nxt;
   logic           periodic, periodic_nxt;
   logic           tick_nxt, wrap_nxt;
   logic           accept, free, snap_load;
   logic           override, hit, at_max, counting;

   assign op        = cnt_op_e'(bus.cmd_op);
   assign accept    = bus.cmd_valid && free;
   assign snap_load = accept && (op == OP_SNAP);
   assign hit       = (count == cmp);
   assign at_max    = (count == '1);

   // CLEAR, LOAD_CNT and STOP pre-empt this cycle's match/wrap processing.
   assign override  = accept && ((op == OP_CLEAR) || (op == OP_LOAD_CNT) || (op == OP_STOP));
   assign counting  = (state == ST_RUN) && !override;

   assign bus.cmd_ready = free;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept) begin
         case (op)
            OP_CLEAR: state_nxt = ST_IDLE;
            OP_START: if (state != ST_RUN) state_nxt = ST_RUN;
            OP_STOP:  state_nxt = ST_IDLE;
            default:  ;
         endcase
      end
      if (counting && hit && !periodic) state_nxt = ST_DONE;
   end

   always_comb begin
      running = (state == ST_RUN);
      done    = (state == ST_DONE);
   end

   always_comb begin
      count_nxt    = count;
      cmp_nxt      = cmp;
      periodic_nxt = periodic;
      tick_nxt     = 1'b0;
      wrap_nxt     = 1'b0;
      if (accept) begin
         case (op)
            OP_CLEAR:    count_nxt = '0;
            OP_LOAD_CMP: cmp_nxt   = bus.cmd_data;
            OP_LOAD_CNT: count_nxt = bus.cmd_data;
            OP_START: begin
               if (state != ST_RUN) periodic_nxt = cfg_periodic;
               if (state == ST_DONE) count_nxt = '0;
            end
            default: ;
         endcase
      end
      // Match outranks wrap, so cmp=all-ones ticks without wrapping.
      if (counting) begin
         if (hit) begin
            tick_nxt = 1'b1;
            if (periodic) count_nxt = '0;
         end else if (at_max) begin
            wrap_nxt  = 1'b1;
            count_nxt = '0;
         end else begin
            count_nxt = count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         cmp      <= '1;
         periodic <= 1'b0;
         tick     <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         count    <= count_nxt;
         cmp      <= cmp_nxt;
         periodic <= periodic_nxt;
         tick     <= tick_nxt;
         wrap     <= wrap_nxt;
      end
   end

   fpga_count_snap #(.ODW(ODW)) u_snap (
      .clk        (clk),
      .rst        (rst),
      .load       (snap_load),
      .load_data  (count),
      .snap_ready (bus.snap_ready),
      .snap_valid (bus.snap_valid),
      .snap_data  (bus.snap_data),
      .free       (free)
   );

endmodule

// File: tb/tb_fpga_count_ctrl.sv
// Directed table-driven bench for fpga_count_ctrl at ODW=8.
module tb_fpga_count_ctrl;

   localparam int ODW = 8;

   typedef struct {
      logic           v;
      logic [2:0]     op;
      logic [ODW-1:0] d;
      logic           per;
      logic           sr;
      logic           rdy0;
      logic [ODW-1:0] cnt;
      logic           run;
      logic           dn;
      logic           tk;
      logic           wr;
      logic           sv;
      logic [ODW-1:0] sd;
      logic           rdy;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_periodic;
   logic [ODW-1:0] count;
   logic           running, done, tick, wrap;

   int total = 0;
   int bad   = 0;
   vec_t tbl[$];

   fpga_count_ctrl_if #(.ODW(ODW)) bus ();

   fpga_count_ctrl #(.ODW(ODW)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .cfg_periodic (cfg_periodic),
      .count        (count),
      .running      (running),
      .done         (done),
      .tick         (tick),
      .wrap         (wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t r(logic v, logic [2:0] op, logic [ODW-1:0] d, logic per, logic sr,
                              logic rdy0, logic [ODW-1:0] cnt, logic run, logic dn, logic tk,
                              logic wr, logic sv, logic [ODW-1:0] sd, logic rdy);
      vec_t t;
      t.v = v; t.op = op; t.d = d; t.per = per; t.sr = sr; t.rdy0 = rdy0;
      t.cnt = cnt; t.run = run; t.dn = dn; t.tk = tk; t.wr = wr;
      t.sv = sv; t.sd = sd; t.rdy = rdy;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d act=0x%0h req=0x%0h", nm, idx, act, exp);
      end
   endtask

   task automatic step(input vec_t t, input int idx);
      bus.cmd_valid   = t.v;
      bus.cmd_op      = t.op;
      bus.cmd_data    = t.d;
      bus.snap_ready  = t.sr;
      cfg_periodic    = t.per;
      #1;
      chk("cmd_ready_pre", idx, 32'(bus.cmd_ready), 32'(t.rdy0));
      @(posedge clk);
      #1;
      chk("count",      idx, 32'(count),          32'(t.cnt));
      chk("running",    idx, 32'(running),        32'(t.run));
      chk("done",       idx, 32'(done),           32'(t.dn));
      chk("tick",       idx, 32'(tick),           32'(t.tk));
      chk("wrap",       idx, 32'(wrap),           32'(t.wr));
      chk("snap_valid", idx, 32'(bus.snap_valid), 32'(t.sv));
      chk("snap_data",  idx, 32'(bus.snap_data),  32'(t.sd));
      chk("cmd_ready",  idx, 32'(bus.cmd_ready),  32'(t.rdy));
   endtask

   initial begin
      // Reset and idle
      for (int i = 0; i < 5; i++) tbl.push_back(r(0,0,0,0,0, 1, 8'h00,0,0,0,0, 0,8'h00,1));
      // One-shot to cmp=4, restart from DONE, stop
      tbl.push_back(r(1,1,8'h04,0,0, 1, 8'h00,0,0,0,0, 0,8'h00,1));
      tbl.push_back(r(1,3,8'h00,0,0, 1, 8'h00,1,0,0,0, 0,8'h00,1));
      for (int i = 1; i <= 4; i++) tbl.push_back(r(0,0,0,0,0, 1, 8'(i),1,0,0,0, 0,8'h00,1));
      tbl.push_back(r(0,0,0,0,0, 1, 8'h04,0,1,1,0, 0,8'h00,1));
      tbl.push_back(r(0,0,0,0,0, 1, 8'h04,0,1,0,0, 0,8'h00,1));
      tbl.push_back(r(1,6,8'h55,0,0, 1, 8'h04,0,1,0,0, 0,8'h00,1));
      tbl.push_back(r(1,3,8'h00,0,0, 1, 8'h00,1,0,0,0, 0,8'h00,1));
      tbl.push_back(r(1,4,8'h00,0,0, 1, 8'h00,0,0,0,0, 0,8'h00,1));
      // Periodic, cmp=2
      tbl.push_back(r(1,1,8'h02,0,0, 1, 8'h00,0,0,0,0, 0,8'h00,1));
      tbl.push_back(r(1,3,8'h00,1,0, 1, 8'h00,1,0,0,0, 0,8'h00,1));
      for (int k = 0; k < 2; k++) begin
         tbl.push_back(r(0,0,0,0,0, 1, 8'h01,1,0,0,0, 0,8'h00,1));
         tbl.push_back(r(0,0,0,0,0, 1, 8'h02,1,0,0,0, 0,8'h00,1));
         tbl.push_back(r(0,0,0,0,0, 1, 8'h00,1,0,1,0, 0,8'h00,1));
      end
      tbl.push_back(r(0,0,0,0,0, 1, 8'h01,1,0,0,0, 0,8'h00,1));
      tbl.push_back(r(1,4,8'h00,0,0, 1, 8'h01,0,0,0,0, 0,8'h00,1));
      // Wrap through 0xFF, cmp=0x10, START in RUN does not resample mode
      tbl.push_back(r(1,2,8'hFE,0,0, 1, 8'hFE,0,0,0,0, 0,8'h00,1));
      tbl.push_back(r(1,1,8'h10,0,0, 1, 8'hFE,0,0,0,0, 0,8'h00,1));
      tbl.push_back(r(1,3,8'h00,0,0, 1, 8'hFE,1,0,0,0, 0,8'h00,1));
      tbl.push_back(r(0,0,0,0,0, 1, 8'hFF,1,0,0,0, 0,8'h00,1));
      tbl.push_back(r(0,0,0,0,0, 1, 8'h00,1,0,0,1, 0,8'h00,1));
      for (int i = 1; i <= 16; i++) begin
         if (i == 8) tbl.push_back(r(1,3,8'h00,1,0, 1, 8'(i),1,0,0,0, 0,8'h00,1));
         else        tbl.push_back(r(0,0,0,0,0, 1, 8'(i),1,0,0,0, 0,8'h00,1));
      end
      tbl.push_back(r(0,0,0,0,0, 1, 8'h10,0,1,1,0, 0,8'h00,1));
      // Snapshot stall then consume with STOP accepted in the same cycle
      tbl.push_back(r(1,3,8'h00,0,0, 1, 8'h00,1,0,0,0, 0,8'h00,1));
      tbl.push_back(r(1,2,8'h20,0,0, 1, 8'h20,1,0,0,0, 0,8'h00,1));
      tbl.push_back(r(0,0,0,0,0, 1, 8'h21,1,0,0,0, 0,8'h00,1));
      tbl.push_back(r(1,5,8'h00,0,0, 1, 8'h22,1,0,0,0, 1,8'h21,0));
      tbl.push_back(r(1,4,8'h00,0,0, 0, 8'h23,1,0,0,0, 1,8'h21,0));
      tbl.push_back(r(1,4,8'h00,0,0, 0, 8'h24,1,0,0,0, 1,8'h21,0));
      tbl.push_back(r(1,4,8'h00,0,1, 1, 8'h24,0,0,0,0, 0,8'h21,1));
      // STOP on the match cycle suppresses tick; LOAD_CMP in RUN matches old cmp
      tbl.push_back(r(1,1,8'h05,0,0, 1, 8'h24,0,0,0,0, 0,8'h21,1));
      tbl.push_back(r(1,2,8'h03,0,0, 1, 8'h03,0,0,0,0, 0,8'h21,1));
      tbl.push_back(r(1,3,8'h00,1,0, 1, 8'h03,1,0,0,0, 0,8'h21,1));
      tbl.push_back(r(0,0,0,0,0, 1, 8'h04,1,0,0,0, 0,8'h21,1));
      tbl.push_back(r(0,0,0,0,0, 1, 8'h05,1,0,0,0, 0,8'h21,1));
      tbl.push_back(r(1,4,8'h00,0,0, 1, 8'h05,0,0,0,0, 0,8'h21,1));
      tbl.push_back(r(0,0,0,0,0, 1, 8'h05,0,0,0,0, 0,8'h21,1));
      tbl.push_back(r(1,3,8'h00,1,0, 1, 8'h05,1,0,0,0, 0,8'h21,1));
      tbl.push_back(r(1,1,8'h09,0,0, 1, 8'h00,1,0,1,0, 0,8'h21,1));
      // Snapshot replaced while being consumed, then drained
      tbl.push_back(r(1,5,8'h00,0,0, 1, 8'h01,1,0,0,0, 1,8'h00,0));
      tbl.push_back(r(1,5,8'h00,0,1, 1, 8'h02,1,0,0,0, 1,8'h01,1));
      tbl.push_back(r(0,0,0,0,1, 1, 8'h03,1,0,0,0, 0,8'h01,1));
      tbl.push_back(r(1,5,8'h00,0,0, 1, 8'h04,1,0,0,0, 1,8'h03,0));

      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_data = '0;
      bus.snap_ready = 1'b0; cfg_periodic = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      foreach (tbl[i]) step(tbl[i], i);

      // Reset mid-RUN with a snapshot pending discards everything
      rst = 1'b1;
      step(r(0,0,0,0,0, 0, 8'h00,0,0,0,0, 0,8'h00,1), 1000);
      rst = 1'b0;

      // Reset cmp is all-ones: one-shot ticks at 0xFF with no wrap; CLEAR returns to IDLE
      step(r(1,2,8'hFD,0,0, 1, 8'hFD,0,0,0,0, 0,8'h00,1), 1001);
      step(r(1,3,8'h00,0,0, 1, 8'hFD,1,0,0,0, 0,8'h00,1), 1002);
      step(r(0,0,0,0,0, 1, 8'hFE,1,0,0,0, 0,8'h00,1), 1003);
      step(r(0,0,0,0,0, 1, 8'hFF,1,0,0,0, 0,8'h00,1), 1004);
      step(r(0,0,0,0,0, 1, 8'hFF,0,1,1,0, 0,8'h00,1), 1005);
      step(r(0,0,0,0,0, 1, 8'hFF,0,1,0,0, 0,8'h00,1), 1006);
      step(r(1,0,8'h00,0,0, 1, 8'h00,0,0,0,0, 0,8'h00,1), 1007);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
